// File: rtl/pll_cfg_pkg.sv
// rtl/pll_cfg_pkg.sv - shared types and register map for the PLL configuration sequencer
//
// Purpose: sequencer state encoding, the request beat handed to the bus
// master, default PLL register addresses and status/control bit positions.
// The PLL register decode in top_pll_system imports the same constants so
// both sides of the bus agree on the map.
// Ports: none (package).

package pll_cfg_pkg;

  // Default register map of the PLL register block
  localparam logic [31:0] PLL_ADDR_CTRL = 32'h0000_0000;
  localparam logic [31:0] PLL_ADDR_CFG  = 32'h0000_0004;
  localparam logic [31:0] PLL_ADDR_STAT = 32'h0000_0008;
  localparam logic [31:0] PLL_ADDR_UPD  = 32'h0000_000C;

  // Lock flag in the status word, bypass select in PLL_CTRL
  localparam int unsigned PLL_LOCK_BIT   = 0;
  localparam int unsigned PLL_BYPASS_BIT = 1;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_WR_CTRL = 4'd1,
    ST_WR_CFG  = 4'd2,
    ST_WR_UPD0 = 4'd3,
    ST_WR_UPD1 = 4'd4,
    ST_RD_STAT = 4'd5,
    ST_WAIT_RD = 4'd6,
    ST_GAP     = 4'd7,
    ST_DONE    = 4'd8,
    ST_ERR     = 4'd9
  } pll_cfg_state_e;

  // One single-beat bus request
  typedef struct packed {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] data;
  } pll_beat_t;

  // States that present a beat on the bus
  function automatic logic pll_is_bus_state(input pll_cfg_state_e s);
    return (s == ST_WR_CTRL) || (s == ST_WR_CFG) || (s == ST_WR_UPD0) ||
           (s == ST_WR_UPD1) || (s == ST_RD_STAT);
  endfunction

  // States whose cycles count toward the lock timeout
  function automatic logic pll_is_polling(input pll_cfg_state_e s);
    return (s == ST_RD_STAT) || (s == ST_WAIT_RD) || (s == ST_GAP);
  endfunction

endpackage

// File: rtl/pll_bus_master_if.sv
// rtl/pll_bus_master_if.sv - registered single-beat bus request holder with read completion
//
// Purpose: holds valid/address/direction/write-data in registers until the
// target accepts them, and reports when the outstanding read completes.
// Ports:
//   clk, rst_n       clock, async active-low reset
//   beat_load        load a new request (only when idle or on the accept edge)
//   beat             request fields to load
//   accept           o_valid && ready this cycle
//   rd_done          the outstanding read completes this cycle (sample rd data now)
//   address, rd0_wr1, wr_data, valid   registered bus request
//   ready, rd_valid  target handshake inputs

module pll_bus_master_if
  import pll_cfg_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        beat_load,
  input  pll_beat_t   beat,
  output logic        accept,
  output logic        rd_done,
  output logic [31:0] address,
  output logic        rd0_wr1,
  output logic [31:0] wr_data,
  output logic        valid,
  input  logic        ready,
  input  logic        rd_valid
);

  logic rd_pending;
  logic rd_accept;

  assign accept    = valid && ready;
  assign rd_accept = accept && !rd0_wr1;
  // Read data may arrive on the accept edge itself or any later cycle.
  assign rd_done   = rd_valid && (rd_pending || rd_accept);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid   <= 1'b0;
      address <= '0;
      rd0_wr1 <= 1'b0;
      wr_data <= '0;
    end else if (beat_load) begin
      valid   <= 1'b1;
      address <= beat.addr;
      rd0_wr1 <= beat.wr;
      wr_data <= beat.data;
    end else if (accept) begin
      valid   <= 1'b0;
    end
  end

  // Only one read in flight; rd_valid outside a pending read is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pending <= 1'b0;
    end else if (rd_accept && !rd_valid) begin
      rd_pending <= 1'b1;
    end else if (rd_valid) begin
      rd_pending <= 1'b0;
    end
  end

endmodule

// File: rtl/pll_cfg_sequencer.sv
// rtl/pll_cfg_sequencer.sv - programs PLL_CTRL/PLL_CFG, pulses update, polls for lock
//
// Purpose: on one accepted start, writes PLL_CTRL, PLL_CFG, UPD=0, UPD=1,
// then (unless bypass is selected) polls the status register until lock or
// timeout, finishing with a one-cycle done or error pulse.
// Ports:
//   i_clk_ahb, reset_n        clock, async active-low reset
//   i_start                   start request (ignored while busy)
//   i_pll_ctrl, i_pll_cfg     values captured on accepted start
//   o_busy, o_done, o_error   sequence status / completion pulses
//   o_status                  last status word read
//   o_address, o_rd0_wr1, o_wr_data, o_valid   bus request
//   i_rd_data, i_rd_valid, i_ready             bus response / handshake

module pll_cfg_sequencer
  import pll_cfg_pkg::*;
#(
  parameter logic [31:0] ADDR_CTRL    = PLL_ADDR_CTRL,
  parameter logic [31:0] ADDR_CFG     = PLL_ADDR_CFG,
  parameter logic [31:0] ADDR_STAT    = PLL_ADDR_STAT,
  parameter logic [31:0] ADDR_UPD     = PLL_ADDR_UPD,
  parameter int unsigned LOCK_BIT     = PLL_LOCK_BIT,
  parameter int unsigned BYPASS_BIT   = PLL_BYPASS_BIT,
  parameter int unsigned LOCK_TIMEOUT = 1024,
  parameter int unsigned POLL_GAP     = 4
) (
  input  logic        i_clk_ahb,
  input  logic        reset_n,
  input  logic        i_start,
  input  logic [31:0] i_pll_ctrl,
  input  logic [31:0] i_pll_cfg,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_error,
  output logic [31:0] o_status,
  output logic [31:0] o_address,
  output logic        o_rd0_wr1,
  output logic [31:0] o_wr_data,
  output logic        o_valid,
  input  logic [31:0] i_rd_data,
  input  logic        i_rd_valid,
  input  logic        i_ready
);

  localparam logic [31:0] TMO_LIMIT = 32'(LOCK_TIMEOUT);
  localparam logic [15:0] GAP_LAST  = 16'(POLL_GAP - 1);

  pll_cfg_state_e state;
  pll_cfg_state_e state_nxt;
  pll_cfg_state_e poll_nxt;

  logic        bypass_q;
  logic [31:0] cfg_q;
  logic [15:0] tmo_cnt;
  logic [15:0] gap_cnt;
  logic        timed_out;

  logic        beat_load;
  pll_beat_t   beat;
  logic        accept;
  logic        rd_done;

  pll_bus_master_if u_bus (
    .clk       (i_clk_ahb),
    .rst_n     (reset_n),
    .beat_load (beat_load),
    .beat      (beat),
    .accept    (accept),
    .rd_done   (rd_done),
    .address   (o_address),
    .rd0_wr1   (o_rd0_wr1),
    .wr_data   (o_wr_data),
    .valid     (o_valid),
    .ready     (i_ready),
    .rd_valid  (i_rd_valid)
  );

  // Timeout only matters when a status read completes; lock wins over timeout.
  assign timed_out = {16'h0000, tmo_cnt} >= TMO_LIMIT;

  always_comb begin
    poll_nxt = ST_GAP;
    if (i_rd_data[LOCK_BIT]) begin
      poll_nxt = ST_DONE;
    end else if (timed_out) begin
      poll_nxt = ST_ERR;
    end
  end

  // State register
  always_ff @(posedge i_clk_ahb or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; a beat is queued on every transition into a bus state,
  // which lets the four writes go out back-to-back.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (i_start) state_nxt = ST_WR_CTRL;
      ST_WR_CTRL: if (accept)  state_nxt = ST_WR_CFG;
      ST_WR_CFG:  if (accept)  state_nxt = ST_WR_UPD0;
      ST_WR_UPD0: if (accept)  state_nxt = ST_WR_UPD1;
      ST_WR_UPD1: if (accept)  state_nxt = bypass_q ? ST_DONE : ST_RD_STAT;
      ST_RD_STAT: begin
        if (rd_done) begin
          state_nxt = poll_nxt;
        end else if (accept) begin
          state_nxt = ST_WAIT_RD;
        end
      end
      ST_WAIT_RD: if (rd_done) state_nxt = poll_nxt;
      ST_GAP:     if (gap_cnt == GAP_LAST) state_nxt = ST_RD_STAT;
      ST_DONE:    state_nxt = ST_IDLE;
      ST_ERR:     state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Request beat for the state being entered. WR_CTRL is only entered from
  // IDLE, so its data comes straight from the input being captured.
  always_comb begin
    beat_load = (state_nxt != state) && pll_is_bus_state(state_nxt);
    beat      = '0;
    case (state_nxt)
      ST_WR_CTRL: begin
        beat.addr = ADDR_CTRL;
        beat.wr   = 1'b1;
        beat.data = i_pll_ctrl;
      end
      ST_WR_CFG: begin
        beat.addr = ADDR_CFG;
        beat.wr   = 1'b1;
        beat.data = cfg_q;
      end
      ST_WR_UPD0: begin
        beat.addr = ADDR_UPD;
        beat.wr   = 1'b1;
        beat.data = 32'h0000_0000;
      end
      ST_WR_UPD1: begin
        beat.addr = ADDR_UPD;
        beat.wr   = 1'b1;
        beat.data = 32'h0000_0001;
      end
      ST_RD_STAT: begin
        beat.addr = ADDR_STAT;
        beat.wr   = 1'b0;
        beat.data = 32'h0000_0000;
      end
      default: beat = '0;
    endcase
  end

  // Outputs
  always_comb begin
    o_busy  = (state != ST_IDLE);
    o_done  = (state == ST_DONE);
    o_error = (state == ST_ERR);
  end

  // Start capture; a start while busy never reaches here since state != IDLE.
  always_ff @(posedge i_clk_ahb or negedge reset_n) begin
    if (!reset_n) begin
      bypass_q <= 1'b0;
      cfg_q    <= '0;
    end else if (state == ST_IDLE && i_start) begin
      bypass_q <= i_pll_ctrl[BYPASS_BIT];
      cfg_q    <= i_pll_cfg;
    end
  end

  // Saturating timeout counter, zero in the first status-read cycle.
  always_ff @(posedge i_clk_ahb or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt <= '0;
    end else if (pll_is_polling(state)) begin
      if (tmo_cnt != 16'hFFFF) begin
        tmo_cnt <= tmo_cnt + 16'd1;
      end
    end else begin
      tmo_cnt <= '0;
    end
  end

  // Idle cycles spent in GAP before the next status read
  always_ff @(posedge i_clk_ahb or negedge reset_n) begin
    if (!reset_n) begin
      gap_cnt <= '0;
    end else if (state == ST_GAP) begin
      gap_cnt <= gap_cnt + 16'd1;
    end else begin
      gap_cnt <= '0;
    end
  end

  always_ff @(posedge i_clk_ahb or negedge reset_n) begin
    if (!reset_n) begin
      o_status <= '0;
    end else if (rd_done) begin
      o_status <= i_rd_data;
    end
  end

endmodule

// File: tb/tb_pll_cfg_sequencer.sv
// tb/tb_pll_cfg_sequencer.sv - directed self-checking bench for pll_cfg_sequencer

module tb_pll_cfg_sequencer;

  localparam int POLL_GAP = 4;
  localparam int LOCK_TMO = 16;

  logic        clk;
  logic        reset_n;
  logic        i_start;
  logic [31:0] i_pll_ctrl;
  logic [31:0] i_pll_cfg;
  logic        o_busy;
  logic        o_done;
  logic        o_error;
  logic [31:0] o_status;
  logic [31:0] o_address;
  logic        o_rd0_wr1;
  logic [31:0] o_wr_data;
  logic        o_valid;
  logic [31:0] i_rd_data;
  logic        i_rd_valid;
  logic        i_ready;

  pll_cfg_sequencer #(
    .LOCK_TIMEOUT (LOCK_TMO),
    .POLL_GAP     (POLL_GAP)
  ) dut (
    .i_clk_ahb  (clk),
    .reset_n    (reset_n),
    .i_start    (i_start),
    .i_pll_ctrl (i_pll_ctrl),
    .i_pll_cfg  (i_pll_cfg),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_error    (o_error),
    .o_status   (o_status),
    .o_address  (o_address),
    .o_rd0_wr1  (o_rd0_wr1),
    .o_wr_data  (o_wr_data),
    .o_valid    (o_valid),
    .i_rd_data  (i_rd_data),
    .i_rd_valid (i_rd_valid),
    .i_ready    (i_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Accepted-beat log and event counters, filled by the monitor
  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];
  logic        log_wr[$];
  int          log_cyc[$];
  int          cyc = 0;
  int          done_cnt = 0;
  int          err_cnt = 0;
  int          done_cyc = 0;
  int          reads_seen = 0;

  // Target behaviour knobs
  int          lock_on = 0;        // read index returning lock, 0 = never
  bit          ready_random = 0;
  int          ready_limit = 1000; // stop accepting after this many beats

  logic        stall_prev = 0;
  logic [31:0] s_addr, s_data;
  logic        s_wr;

  // Monitor: sampled on the falling edge, away from the active edge
  always @(negedge clk) begin
    cyc++;
    if (reset_n) begin
      if (stall_prev) begin
        check("stall_valid", 32'(o_valid), 32'h1);
        check("stall_addr", o_address, s_addr);
        check("stall_data", o_wr_data, s_data);
        check("stall_wr", 32'(o_rd0_wr1), 32'(s_wr));
      end
      if (o_valid && i_ready) begin
        log_addr.push_back(o_address);
        log_data.push_back(o_wr_data);
        log_wr.push_back(o_rd0_wr1);
        log_cyc.push_back(cyc);
      end
      stall_prev = o_valid && !i_ready;
      s_addr = o_address;
      s_data = o_wr_data;
      s_wr   = o_rd0_wr1;
      if (o_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (o_error) err_cnt++;
    end else begin
      stall_prev = 0;
    end
  end

  // Register-block model: same-cycle read response on accept
  initial begin
    i_ready = 1'b0;
    i_rd_valid = 1'b0;
    i_rd_data = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (log_addr.size() >= ready_limit) i_ready = 1'b0;
      else if (ready_random) i_ready = 1'($urandom_range(0, 1));
      else i_ready = 1'b1;
      i_rd_valid = o_valid && !o_rd0_wr1 && i_ready;
      if (i_rd_valid) begin
        reads_seen++;
        i_rd_data = (reads_seen == lock_on) ? 32'h0000_00F1 : 32'h0000_00F0;
      end else begin
        i_rd_data = 32'hDEAD_0000;
      end
    end
  end

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
    log_wr.delete();
    log_cyc.delete();
    done_cnt = 0;
    err_cnt = 0;
    reads_seen = 0;
  endtask

  task automatic start_seq(input logic [31:0] c, input logic [31:0] f);
    @(posedge clk);
    #1;
    i_start = 1'b1;
    i_pll_ctrl = c;
    i_pll_cfg = f;
    @(posedge clk);
    #1;
    i_start = 1'b0;
  endtask

  task automatic wait_end(input string tag);
    int n;
    n = 0;
    while (done_cnt == 0 && err_cnt == 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    if (n >= 300) check({tag, "_end_timeout"}, 32'h0, 32'h1);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic check_writes(input string tag, input logic [31:0] c, input logic [31:0] f);
    logic [31:0] ea[4];
    logic [31:0] ed[4];
    ea = '{32'h0, 32'h4, 32'hC, 32'hC};
    ed = '{c, f, 32'h0, 32'h1};
    if (log_addr.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("%s_wa%0d", tag, i), log_addr[i], ea[i]);
        check($sformatf("%s_wd%0d", tag, i), log_data[i], ed[i]);
        check($sformatf("%s_ww%0d", tag, i), 32'(log_wr[i]), 32'h1);
      end
    end else begin
      check({tag, "_few_beats"}, log_addr.size(), 32'd4);
    end
  endtask

  task automatic check_reads(input string tag, input int first, input int n);
    for (int i = first; i < first + n && i < log_addr.size(); i++) begin
      check($sformatf("%s_ra%0d", tag, i), log_addr[i], 32'h8);
      check($sformatf("%s_rw%0d", tag, i), 32'(log_wr[i]), 32'h0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    i_start = 1'b0;
    i_pll_ctrl = 32'h0;
    i_pll_cfg = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(o_busy), 32'h0);
    check("rst_valid", 32'(o_valid), 32'h0);
    check("rst_done", 32'(o_done), 32'h0);
    check("rst_error", 32'(o_error), 32'h0);
    check("rst_status", o_status, 32'h0);
    check("rst_addr", o_address, 32'h0);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);

    // Normal: lock on the second status read
    clear_log();
    lock_on = 2;
    start_seq(32'h1, 32'h0000_0F03);
    check("nrm_busy_rise", 32'(o_busy), 32'h1);
    wait_end("nrm");
    check("nrm_beats", log_addr.size(), 32'd6);
    check_writes("nrm", 32'h1, 32'h0000_0F03);
    check_reads("nrm", 4, 2);
    if (log_cyc.size() >= 6) begin
      for (int i = 0; i < 3; i++)
        check($sformatf("nrm_b2b%0d", i), log_cyc[i+1] - log_cyc[i], 32'd1);
      check("nrm_read_gap", log_cyc[5] - log_cyc[4], 32'(POLL_GAP + 1));
    end
    check("nrm_reads", reads_seen, 32'd2);
    check("nrm_done", done_cnt, 32'd1);
    check("nrm_err", err_cnt, 32'd0);
    check("nrm_status", o_status, 32'h0000_00F1);
    check("nrm_busy_fall", 32'(o_busy), 32'h0);

    // Bypass, with a second start while busy that must be dropped
    clear_log();
    lock_on = 1;
    start_seq(32'h3, 32'h0000_030B);
    start_seq(32'hFFFF_FFFF, 32'hDEAD_BEEF);
    wait_end("byp");
    repeat (20) @(posedge clk);
    #1;
    check("byp_beats", log_addr.size(), 32'd4);
    check_writes("byp", 32'h3, 32'h0000_030B);
    if (log_cyc.size() >= 4) check("byp_done_cyc", done_cyc, 32'(log_cyc[3] + 1));
    check("byp_reads", reads_seen, 32'd0);
    check("byp_done", done_cnt, 32'd1);

    // Backpressure: random ready, lock on first read
    clear_log();
    ready_random = 1;
    lock_on = 1;
    start_seq(32'h1, 32'h1234_5602);
    wait_end("bp");
    ready_random = 0;
    check("bp_beats", log_addr.size(), 32'd5);
    check_writes("bp", 32'h1, 32'h1234_5602);
    check_reads("bp", 4, 1);
    check("bp_done", done_cnt, 32'd1);
    check("bp_status", o_status, 32'h0000_00F1);

    // Timeout: never locks; reads at counts 0,5,10,15,20 -> error on the fifth
    clear_log();
    lock_on = 0;
    start_seq(32'h1, 32'h0000_0011);
    wait_end("tmo");
    check("tmo_reads", reads_seen, 32'd5);
    check("tmo_beats", log_addr.size(), 32'd9);
    check_reads("tmo", 4, 5);
    check("tmo_err", err_cnt, 32'd1);
    check("tmo_done", done_cnt, 32'd0);
    check("tmo_busy", 32'(o_busy), 32'h0);
    check("tmo_status", o_status, 32'h0000_00F0);
    clear_log();
    start_seq(32'h2, 32'h0000_0022);
    wait_end("tmo_re");
    check("tmo_re_done", done_cnt, 32'd1);
    check_writes("tmo_re", 32'h2, 32'h0000_0022);

    // Reset while stalled in WR_CFG
    clear_log();
    ready_limit = 1;
    start_seq(32'h1, 32'h0000_0007);
    repeat (3) @(posedge clk);
    #1;
    check("rmid_in_cfg_valid", 32'(o_valid), 32'h1);
    check("rmid_in_cfg_addr", o_address, 32'h4);
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("rmid_valid_async", 32'(o_valid), 32'h0);
    check("rmid_busy", 32'(o_busy), 32'h0);
    check("rmid_status", o_status, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    ready_limit = 1000;
    repeat (5) @(posedge clk);
    check("rmid_no_done", done_cnt, 32'd0);
    check("rmid_no_err", err_cnt, 32'd0);
    clear_log();
    start_seq(32'h3, 32'h0000_0055);
    wait_end("rmid_re");
    check("rmid_re_beats", log_addr.size(), 32'd4);
    check_writes("rmid_re", 32'h3, 32'h0000_0055);
    check("rmid_re_done", done_cnt, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pll_cfg_sequencer.md
Name: pll_cfg_sequencer

Overview:
Bus initiator that programs the PLL register block over the single-beat register interface: address, rd0/wr1 flag, write data, valid, ready, read data and read valid. On one start command it writes PLL_CTRL and PLL_CFG, pulses the update register (0 then 1), then polls the PLL status register until lock or timeout. It sits between the boot/clock-management FSM and top_pll_system, and replaces hand-sequenced software writes.

Parameters:
ADDR_CTRL, 32'h0, PLL_CTRL register address
ADDR_CFG, 32'h4, PLL_CFG register address
ADDR_STAT, 32'h8, PLL status register address (read-only)
ADDR_UPD, 32'hC, update/trigger register address
LOCK_BIT, 0, bit index of lock flag in status word
BYPASS_BIT, 1, bit index in PLL_CTRL selecting bypass (skip lock poll)
LOCK_TIMEOUT, 1024, max cycles from first status read to lock; 0 is illegal
POLL_GAP, 4, idle cycles between status reads (>=1)

Ports:
i_clk_ahb  in  1  clock (same domain as the register block)
reset_n  in  1  async active-low reset
i_start  in  1  1-cycle start request; ignored while o_busy
i_pll_ctrl  in  32  PLL_CTRL value, captured on accepted i_start
i_pll_cfg  in  32  PLL_CFG value, captured on accepted i_start
o_busy  out  1  sequence in progress
o_done  out  1  1-cycle pulse: sequence finished successfully
o_error  out  1  1-cycle pulse: lock timeout
o_status  out  32  last status word read (held)
o_address  out  32  bus address
o_rd0_wr1  out  1  0 = read, 1 = write
o_wr_data  out  32  bus write data
o_valid  out  1  bus request valid
i_rd_data  in  32  bus read data
i_rd_valid  in  1  read data valid
i_ready  in  1  target ready; beat accepted when o_valid && i_ready at rising edge

Behaviour:
- Reset: all outputs 0; FSM in IDLE; captured regs and counters cleared. Reset mid-sequence aborts immediately: o_valid drops asynchronously and no done/error pulse is issued.
- Bus rules:
  - o_valid, o_address, o_rd0_wr1 and o_wr_data are registered and held stable until accepted.
  - After acceptance, o_valid deasserts the next cycle unless the next beat is issued back-to-back (writes only).
  - A read completes on the first i_rd_valid at or after its accept edge; i_rd_data is sampled that cycle. Same-cycle rd_valid is legal.
  - At most one read outstanding. Stray i_rd_valid outside WAIT_RD is ignored.
- FSM:
  - IDLE: o_busy=0. On i_start: capture ctrl/cfg, go to WR_CTRL. o_busy rises the cycle after i_start.
  - WR_CTRL: write i_pll_ctrl to ADDR_CTRL; on accept -> WR_CFG.
  - WR_CFG: write cfg to ADDR_CFG; on accept -> WR_UPD0.
  - WR_UPD0: write 32'h0 to ADDR_UPD; on accept -> WR_UPD1.
  - WR_UPD1: write 32'h1 to ADDR_UPD; on accept -> DONE if ctrl[BYPASS_BIT]=1, else RD_STAT (timeout counter cleared).
  - RD_STAT: read ADDR_STAT (o_wr_data=0); on accept -> WAIT_RD.
  - WAIT_RD: on i_rd_valid: load o_status. If status[LOCK_BIT]=1 -> DONE; else if timeout reached -> ERR; else -> GAP.
  - GAP: idle POLL_GAP cycles -> RD_STAT.
  - DONE: o_done=1 for one cycle -> IDLE. ERR: o_error=1 for one cycle -> IDLE.
- Timeout counter: 16-bit, saturating. Increments every cycle in RD_STAT, WAIT_RD and GAP. Timeout = count >= LOCK_TIMEOUT, checked only at read completion, so a lock seen in the same read as the timeout wins (DONE).
- With back-to-back i_ready=1, the four writes occupy 4 consecutive cycles and o_valid stays high.
- i_ready low stalls any state indefinitely; stalled cycles count toward the timeout only in polling states.
- i_start while busy: dropped, no effect on captured values.

Decomposition:
- Package pll_cfg_pkg: state enum, default register address localparams, LOCK_BIT/BYPASS_BIT localparams. top_pll_system's register decode should share these.
- One sub-module, pll_bus_master_if: registered valid/address/data holding plus read-completion detection. The FSM issues requests through it.

Test Plan:
- Normal: ctrl=32'h1, cfg=32'h0000_0F03, i_ready=1, status lock returned on the 2nd read -> writes (0x0,0x1),(0x4,0xF03),(0xC,0),(0xC,1) on consecutive cycles; exactly 2 reads at 0x8, separated by POLL_GAP; o_done pulse; o_status lock bit=1.
- Bypass: ctrl=32'h3, cfg=32'h30B -> four writes, no status read, o_done one cycle after the last accept.
- Backpressure: i_ready toggled pseudo-randomly -> o_valid/o_address/o_wr_data never change while o_valid && !i_ready; write order and values are unchanged.
- Timeout: LOCK_TIMEOUT=16, status always 0 -> o_error pulse once, no o_done, o_busy falls; i_start re-accepted afterwards.
- Reset mid-WR_CFG: reset_n low -> o_valid=0 immediately, o_busy=0, no pulses; a fresh i_start restarts from WR_CTRL.
- i_start asserted while busy with different ctrl/cfg -> ignored; bus writes carry the originally captured values.
